// File: rtl/fx68k_ucode_loader_if.sv
// Byte-stream sink and control-store write port of the microcode loader.
// The loader uses the slave view; the host or bench uses the master view.
interface fx68k_ucode_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;

  modport master (
    output s_data, s_valid,
    input  s_ready, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/fx68k_ucode_loader.sv
// Runtime loader for the fx68k control store: packs a little-endian byte stream
// into DATA_WIDTH words, strobes them into the RAM and verifies a trailing checksum.
module fx68k_ucode_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1 << ADDR_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_ena_i,
  input  logic start_i,
  fx68k_ucode_loader_if.slave bus,
  output logic busy_o,
  output logic done_o,
  output logic error_o
);

  localparam int BYTES = (DATA_WIDTH + 7) / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] PREV_ADDR = ADDR_WIDTH'(WORDS - 2);
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;

  state_e                state_q;
  logic [BCW-1:0]        byte_cnt_q;
  logic [7:0]            sum_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] asm_d;
  logic [7:0]            sum_d;
  logic [BCW+2:0]        shift;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;

  // During a strobe the word being assembled is one past the address on the port.
  always_comb begin
    shift     = {byte_cnt_q, 3'b000};
    asm_d     = (asm_q & ~(BYTE_MASK << shift)) | (DATA_WIDTH'(bus.s_data) << shift);
    sum_d     = sum_q + bus.s_data;
    accept    = bus.s_valid & busy_q & clk_ena_i;
    last_byte = (byte_cnt_q == BCW'(BYTES - 1));
    last_word = wr_en_q ? (wr_addr_q == PREV_ADDR) : (wr_addr_q == LAST_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      asm_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (clk_ena_i) begin
      wr_en_q <= 1'b0;
      if (wr_en_q && (wr_addr_q != LAST_ADDR)) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            wr_addr_q  <= '0;
            byte_cnt_q <= '0;
            sum_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            sum_q <= sum_d;
            asm_q <= asm_d;
            if (last_byte) begin
              byte_cnt_q <= '0;
              wr_data_q  <= asm_d;
              wr_en_q    <= 1'b1;
              if (last_word) begin
                state_q <= CHECK;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            sum_q   <= sum_d;
            done_q  <= 1'b1;
            error_q <= (sum_d != 8'd0);
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = busy_q & clk_ena_i;
  assign bus.wr_en   = wr_en_q & clk_ena_i;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_fx68k_ucode_loader.sv
// Directed bench for the microcode loader with a 4-word, 17-bit control store.
module tb_fx68k_ucode_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_ena;
  logic start;
  logic busy;
  logic done;
  logic error;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int wrCount    = 0;
  int stallMode  = 0;
  logic [31:0] wrAddrLog [0:15];
  logic [31:0] wrDataLog [0:15];
  int          wrCycleLog[0:15];
  logic [31:0] expData   [0:3];

  fx68k_ucode_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(17)) ifc ();

  fx68k_ucode_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(17), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_ena_i (clk_ena),
    .start_i   (start),
    .bus       (ifc),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Log every visible strobe; a strobe must never be visible while the clock enable is low.
  always @(negedge clk) begin
    if (ifc.wr_en === 1'b1) begin
      checkOutput("wr_en_while_ena_low", {31'd0, clk_ena}, 32'd1);
      if (wrCount < 16) begin
        wrAddrLog[wrCount]  = 32'(ifc.wr_addr);
        wrDataLog[wrCount]  = 32'(ifc.wr_data);
        wrCycleLog[wrCount] = cycle;
      end
      wrCount++;
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    if (stallMode != 0) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ifc.s_data  = b;
    ifc.s_valid = 1'b1;
    if (stallMode != 0 && $urandom_range(0, 2) == 0) begin
      clk_ena = 1'b0;
      repeat (3) begin
        @(negedge clk);
        checkOutput("s_ready_while_ena_low", {31'd0, ifc.s_ready}, 32'd0);
        @(posedge clk);
        #1;
      end
      clk_ena = 1'b1;
    end
    waited = 0;
    @(negedge clk);
    while (ifc.s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (ifc.s_ready !== 1'b1) checkOutput("accept_timeout", {31'd0, ifc.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    ifc.s_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_count"}, 32'(wrCount), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), wrAddrLog[i], 32'(i));
      checkOutput($sformatf("%s_data%0d", tag, i), wrDataLog[i], expData[i]);
    end
  endtask

  task automatic checkFinished(input string tag, input logic expError);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_done"},  {31'd0, done},  32'd1);
    checkOutput({tag, "_error"}, {31'd0, error}, {31'd0, expError});
    checkOutput({tag, "_busy"},  {31'd0, busy},  32'd0);
    checkOutput({tag, "_ready"}, {31'd0, ifc.s_ready}, 32'd0);
    checkOutput({tag, "_addr"},  32'(ifc.wr_addr), 32'd3);
  endtask

  initial begin
    rst_n       = 1'b0;
    clk_ena     = 1'b1;
    start       = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = 8'h00;
    expData[0]  = 32'h11234;
    expData[1]  = 32'h11235;
    expData[2]  = 32'h11236;
    expData[3]  = 32'h11237;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready",   {31'd0, ifc.s_ready}, 32'd0);
    checkOutput("rst_wr_en",   {31'd0, ifc.wr_en},   32'd0);
    checkOutput("rst_busy",    {31'd0, busy},        32'd0);
    checkOutput("rst_done",    {31'd0, done},        32'd0);
    checkOutput("rst_error",   {31'd0, error},       32'd0);
    checkOutput("rst_wr_addr", 32'(ifc.wr_addr),     32'd0);
    checkOutput("rst_wr_data", 32'(ifc.wr_data),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back load: words sum to 0x47+0x48+0x49+0x4A = 0x122, so the check byte is 0xDE.
    $display("[TB] basic back-to-back load");
    wrCount = 0;
    pulseStart();
    @(negedge clk);
    checkOutput("a_busy_after_start", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) sendWord(8'h34 + 8'(k), 8'h12, 8'h01);
    applyStimulus(8'hDE);
    checkFinished("a", 1'b0);
    checkWrites("a");
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("a_gap%0d", i), 32'(wrCycleLog[i] - wrCycleLog[i-1]), 32'd3);

    // Re-arm from DONE, stalled stream, wrong check byte.
    $display("[TB] stalled load with bad checksum");
    pulseStart();
    @(negedge clk);
    checkOutput("b_rearm_done",  {31'd0, done},  32'd0);
    checkOutput("b_rearm_error", {31'd0, error}, 32'd0);
    checkOutput("b_rearm_addr",  32'(ifc.wr_addr), 32'd0);
    @(posedge clk);
    #1;
    wrCount   = 0;
    stallMode = 1;
    for (int k = 0; k < 4; k++) sendWord(8'h34 + 8'(k), 8'h12, 8'h01);
    applyStimulus(8'hDF);
    stallMode = 0;
    checkFinished("b", 1'b1);
    checkWrites("b");

    // Abandon a load with an asynchronous reset after word 1's second byte.
    $display("[TB] reset mid-load");
    pulseStart();
    sendWord(8'h34, 8'h12, 8'h01);
    applyStimulus(8'h35);
    applyStimulus(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("c_rst_wr_en", {31'd0, ifc.wr_en},   32'd0);
    checkOutput("c_rst_busy",  {31'd0, busy},        32'd0);
    checkOutput("c_rst_done",  {31'd0, done},        32'd0);
    checkOutput("c_rst_ready", {31'd0, ifc.s_ready}, 32'd0);
    checkOutput("c_rst_addr",  32'(ifc.wr_addr),     32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh load with a truncated all-ones first word; sum 0x2FD+0xDB -> 0xD8, check 0x28.
    $display("[TB] fresh load with truncation and ignored start");
    wrCount    = 0;
    expData[0] = 32'h1FFFF;
    pulseStart();
    sendWord(8'hFF, 8'hFF, 8'hFF);
    pulseStart();
    @(negedge clk);
    checkOutput("d_start_in_load_addr", 32'(ifc.wr_addr), 32'd1);
    checkOutput("d_start_in_load_busy", {31'd0, busy},    32'd1);
    @(posedge clk);
    #1;
    for (int k = 1; k < 4; k++) sendWord(8'h34 + 8'(k), 8'h12, 8'h01);
    applyStimulus(8'h28);
    checkFinished("d", 1'b0);
    checkWrites("d");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
